logic_issue: RTL and testbench

Upstream issue stage for the 16-bit logic unit. Accepts operation requests (A, B, 3-bit code) over a valid/ready handshake, buffers them in a small FIFO, and presents one request at a time on registered operand/code lines to the combinational logic unit. The unit's result is captured and returned over a second valid/ready handshake. Illegal codes are flagged.

---
 rtl/logic_issue.sv | 180 ++++++++++++++++++
 tb/tb_logic_issue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_issue.sv
// rtl/logic_issue.sv - issue stage feeding a combinational 16-bit logic unit
//
// Purpose: accepts (A, B, code) requests over a valid/ready handshake, queues
// them in a DEPTH-entry FIFO, presents one request at a time on registered
// lu_* lines, captures the unit's result and returns it over a second
// valid/ready handshake. Illegal codes return a zero result with out_err set.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        request handshake; in_a, in_b, in_code payload
//   lu_a, lu_b, lu_code      registered operands/code to the logic unit
//   lu_c                     combinational result from the logic unit
//   out_valid/out_ready      result handshake; out_c, out_code, out_err payload
//   busy                     FIFO non-empty or request in flight
module logic_issue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_code,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_code,
  input  logic [WIDTH-1:0] lu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [2:0]       out_code,
  output logic             out_err,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]       code;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } req_t;

  function automatic logic illegal_code(input logic [2:0] c);
    return !((c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b100));
  endfunction

  state_t           state_q, state_d;
  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic [2:0]       lu_code_q, lu_code_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [2:0]       out_code_q, out_code_d;
  logic             out_err_q, out_err_d;

  logic push;
  logic pop;
  req_t head;

  // in_ready depends only on the registered count, so a pop in the same
  // cycle never frees a slot for a push while full.
  assign in_ready  = (count_q < FULL);
  assign busy      = (count_q != '0) || (state_q != S_IDLE);
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_code   = lu_code_q;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_code  = out_code_q;
  assign out_err   = out_err_q;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_code_d   = lu_code_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    pop         = 1'b0;
    push        = in_valid && in_ready;
    head        = mem_q[rd_ptr_q];

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // lu_* have been stable for a full cycle; sample the unit once.
        out_c_d     = illegal_code(lu_code_q) ? '0 : lu_c;
        out_code_d  = lu_code_q;
        out_err_d   = illegal_code(lu_code_q);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      lu_a_d    = head.a;
      lu_b_d    = head.b;
      lu_code_d = head.code;
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end

    // A pop only happens with count > 0, so the write slot never aliases
    // the head being read in the same cycle.
    if (push) begin
      mem_d[wr_ptr_q] = '{code: in_code, b: in_b, a: in_a};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_code_q   <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_code_q   <= lu_code_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_logic_issue.sv
// tb/tb_logic_issue.sv - directed bench for logic_issue
module tb_logic_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_code;
  logic [15:0] lu_a;
  logic [15:0] lu_b;
  logic [2:0]  lu_code;
  logic [15:0] lu_c;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic [2:0]  out_code;
  logic        out_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // expected results, {code, c}, consumed in order by drain()
  logic [18:0] exp_q [$];

  logic_issue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_code(in_code),
    .lu_a(lu_a), .lu_b(lu_b), .lu_code(lu_code), .lu_c(lu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_code(out_code), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Logic unit stand-in: AND, OR, XOR, NOT A; garbage on illegal codes.
  always_comb begin
    case (lu_code)
      3'b000:  lu_c = lu_a & lu_b;
      3'b001:  lu_c = lu_a | lu_b;
      3'b010:  lu_c = lu_a ^ lu_b;
      3'b100:  lu_c = ~lu_a;
      default: lu_c = 16'hDEAD;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_code  = c;
  endtask

  // Hold out_ready=1 and collect n results, pushing any pending request.
  task automatic drain(input int n);
    int k = 0;
    int cyc = 0;
    logic acc;
    logic [18:0] e;
    out_ready = 1'b1;
    while (k < n && cyc < 80) begin
      if (out_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 19'h7FFFF;
        chk("drain_c", {16'h0, out_c}, {16'h0, e[15:0]});
        chk("drain_code", {29'h0, out_code}, {29'h0, e[18:16]});
        k++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    chk("drain_count", k, n);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_code = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_lu_a", {16'h0, lu_a}, 0);
    chk("rst_out_c", {16'h0, out_c}, 0);

    // single request: XOR, 2-edge latency
    drive(16'hF0F0, 16'h0FF0, 3'b010);
    step();
    in_valid = 1'b0;
    chk("single_busy", {31'h0, busy}, 1);
    chk("single_ov_e0", {31'h0, out_valid}, 0);
    step();
    chk("single_lu_a", {16'h0, lu_a}, 32'hF0F0);
    chk("single_lu_b", {16'h0, lu_b}, 32'h0FF0);
    chk("single_lu_code", {29'h0, lu_code}, 2);
    chk("single_ov_e1", {31'h0, out_valid}, 0);
    step();
    chk("single_ov_e2", {31'h0, out_valid}, 1);
    chk("single_out_c", {16'h0, out_c}, 32'hFF00);
    chk("single_out_code", {29'h0, out_code}, 2);
    chk("single_out_err", {31'h0, out_err}, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_ov_after", {31'h0, out_valid}, 0);
    chk("single_idle", {31'h0, busy}, 0);

    // illegal code then a legal one
    drive(16'hFFFF, 16'hFFFF, 3'b111);
    step(); in_valid = 1'b0; step(); step();
    chk("ill_ov", {31'h0, out_valid}, 1);
    chk("ill_err", {31'h0, out_err}, 1);
    chk("ill_c", {16'h0, out_c}, 0);
    chk("ill_code", {29'h0, out_code}, 7);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    drive(16'h1234, 16'h0F0F, 3'b000);
    step(); in_valid = 1'b0; step(); step();
    chk("legal_err", {31'h0, out_err}, 0);
    chk("legal_c", {16'h0, out_c}, 32'h0204);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // back-pressure: result and lu_* frozen while out_ready=0
    drive(16'hAAAA, 16'h5555, 3'b001);
    step();
    drive(16'h00FF, 16'h0F0F, 3'b100);
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", {31'h0, out_valid}, 1);
      chk("bp_c", {16'h0, out_c}, 32'hFFFF);
      chk("bp_code", {29'h0, out_code}, 1);
      chk("bp_err", {31'h0, out_err}, 0);
      chk("bp_lu_a", {16'h0, lu_a}, 32'hAAAA);
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_pop_lu_a", {16'h0, lu_a}, 32'h00FF);
    chk("bp_pop_ov", {31'h0, out_valid}, 0);
    step();
    chk("bp_second_c", {16'h0, out_c}, 32'hFF00);
    chk("bp_second_code", {29'h0, out_code}, 4);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_idle", {31'h0, busy}, 0);

    // fill/full: 6 pushes with out_ready=0
    drive(16'h1111, 16'h00FF, 3'b000); step();
    drive(16'h2222, 16'h0F0F, 3'b001); step();
    drive(16'h3333, 16'hFFFF, 3'b010); step();
    drive(16'h4444, 16'h0000, 3'b100); step();
    drive(16'h5555, 16'h0F0F, 3'b000); step();
    drive(16'h6666, 16'h1111, 3'b001);
    chk("full_in_ready", {31'h0, in_ready}, 0);
    step(); step();
    chk("full_in_ready_hold", {31'h0, in_ready}, 0);
    chk("full_lu_a", {16'h0, lu_a}, 32'h1111);
    exp_q.push_back({3'b000, 16'h0011});
    exp_q.push_back({3'b001, 16'h2F2F});
    exp_q.push_back({3'b010, 16'hCCCC});
    exp_q.push_back({3'b100, 16'hBBBB});
    exp_q.push_back({3'b000, 16'h0505});
    exp_q.push_back({3'b001, 16'h7777});
    drain(6);
    chk("full_idle", {31'h0, busy}, 0);

    // simultaneous pop and push with count=2 in DONE
    drive(16'h000F, 16'h00F0, 3'b001); step();
    drive(16'hFFFF, 16'h1234, 3'b000); step();
    drive(16'hABCD, 16'hFFFF, 3'b010); step();
    in_valid = 1'b0;
    chk("sim_ov", {31'h0, out_valid}, 1);
    chk("sim_c0", {16'h0, out_c}, 32'h00FF);
    out_ready = 1'b1;
    drive(16'h0F0F, 16'h0000, 3'b100);
    step();
    in_valid = 1'b0;
    chk("sim_ov_after", {31'h0, out_valid}, 0);
    chk("sim_lu_a", {16'h0, lu_a}, 32'hFFFF);
    chk("sim_lu_b", {16'h0, lu_b}, 32'h1234);
    exp_q.push_back({3'b000, 16'h1234});
    exp_q.push_back({3'b010, 16'h5432});
    exp_q.push_back({3'b100, 16'hF0F0});
    drain(3);
    chk("sim_idle", {31'h0, busy}, 0);

    // reset mid-operation: ISSUE with count=3
    for (int i = 0; i < 5; i++) begin
      drive(16'h8888, 16'h7777, 3'b001);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("mid_lu_a", {16'h0, lu_a}, 32'h8888);
    chk("mid_out_c", {16'h0, out_c}, 32'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", {31'h0, out_valid}, 0);
    chk("mid_rst_out_c", {16'h0, out_c}, 0);
    chk("mid_rst_out_code", {29'h0, out_code}, 0);
    chk("mid_rst_out_err", {31'h0, out_err}, 0);
    chk("mid_rst_lu_a", {16'h0, lu_a}, 0);
    chk("mid_rst_lu_b", {16'h0, lu_b}, 0);
    chk("mid_rst_lu_code", {29'h0, lu_code}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 1);
    step();
    rst = 1'b0;
    step();
    drive(16'hFFFF, 16'h00FF, 3'b000);
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_ov_e1", {31'h0, out_valid}, 0);
    chk("post_rst_lu_a", {16'h0, lu_a}, 32'hFFFF);
    step();
    chk("post_rst_ov_e2", {31'h0, out_valid}, 1);
    chk("post_rst_c", {16'h0, out_c}, 32'h00FF);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    step();
    chk("post_rst_discarded", {31'h0, busy}, 0);
    chk("post_rst_no_extra", {31'h0, out_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
